// File: rtl/upc_serial_tx.sv
// rtl/upc_serial_tx.sv - framed, even-parity serial transmitter for UPC codes
//
// Purpose:
//   Shifts a captured UPC code onto a single idle-high wire as
//   start(0) | data LSB first | even parity | stop(1), with each bit held
//   for CLKS_PER_BIT cycles.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  asynchronous, active-high reset
//   i_send   transmit request, accepted when o_ready is high on the same edge
//   i_upc    code to transmit, captured on acceptance only
//   o_ready  high while a new i_send will be accepted
//   o_tx     serial line, idles high
//   o_done   one-cycle pulse when a frame's stop bit completes
module upc_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_send,
  input  logic [DATA_W-1:0] i_upc,
  output logic              o_ready,
  output logic              o_tx,
  output logic              o_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [BIT_W-1:0]    r_bit_idx;
  logic [DATA_W-1:0]   r_shift;
  logic                r_parity;
  logic                r_tx;
  logic                r_ready;
  logic                r_done;

  state_t              w_state_n;
  logic [CNT_W-1:0]    w_cnt_n;
  logic [BIT_W-1:0]    w_bit_idx_n;
  logic [DATA_W-1:0]   w_shift_n;
  logic                w_parity_n;
  logic                w_tx_n;
  logic                w_ready_n;
  logic                w_done_n;
  logic                w_bit_end;

  // Last cycle of the current frame bit.
  assign w_bit_end = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_bit_idx_n = r_bit_idx;
    w_shift_n   = r_shift;
    w_parity_n  = r_parity;

    case (r_state)
      S_IDLE: begin
        if (i_send) begin
          w_state_n   = S_START;
          w_cnt_n     = '0;
          w_bit_idx_n = '0;
          w_shift_n   = i_upc;
          w_parity_n  = ^i_upc;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_n   = S_DATA;
          w_cnt_n     = '0;
          w_bit_idx_n = '0;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_n   = '0;
          w_shift_n = r_shift >> 1;
          if (r_bit_idx == BIT_LAST) begin
            w_state_n = S_PARITY;
          end else begin
            w_bit_idx_n = r_bit_idx + BIT_W'(1);
          end
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_n = S_STOP;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  // Outputs are registered: derive them from the state being entered so
  // they line up with that state's first cycle.
  always_comb begin
    w_tx_n = 1'b1;
    case (w_state_n)
      S_IDLE:   w_tx_n = 1'b1;
      S_START:  w_tx_n = 1'b0;
      S_DATA:   w_tx_n = w_shift_n[0];
      S_PARITY: w_tx_n = w_parity_n;
      S_STOP:   w_tx_n = 1'b1;
      default:  w_tx_n = 1'b1;
    endcase
    w_ready_n = (w_state_n == S_IDLE);
    w_done_n  = (r_state == S_STOP) && w_bit_end;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_bit_idx <= w_bit_idx_n;
      r_shift   <= w_shift_n;
      r_parity  <= w_parity_n;
      r_tx      <= w_tx_n;
      r_ready   <= w_ready_n;
      r_done    <= w_done_n;
    end
  end

  assign o_tx    = r_tx;
  assign o_ready = r_ready;
  assign o_done  = r_done;

endmodule
